// File: rtl/exin_adc_avg.sv
// exin_adc_avg: sliding-window mean of ADC0832 conversions with hysteresis alarm.
// Each rising edge of the reader's finish flag captures one 8-bit sample into a
// 2^AVG_LOG2 deep window. A running sum is updated in place: the oldest sample is
// subtracted and the new one added, so no adder tree is needed.
// Pipeline: edge detect/sample latch -> window/sum update -> avg/alarm update.
// Optional feature macro: ADC_MINMAX_EN adds min_val/max_val tracking of avg.
//
// Handshake: finish/sample have no back-pressure; a capture happens on each
// 0->1 transition of finish, taking sample from that same cycle. avg_valid is a
// single-cycle strobe with no ready; a consumer must take avg while it is high.
module exin_adc_avg #(
  parameter int         AVG_LOG2 = 3,
  parameter logic [7:0] HI_TH    = 8'd200,
  parameter logic [7:0] LO_TH    = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       finish,
  input  logic [7:0] sample,
  input  logic       clr,
  output logic [7:0] avg,
  output logic       avg_valid,
  output logic       full,
  output logic       alarm,
  output logic       state_dbg
`ifdef ADC_MINMAX_EN
  ,
  output logic [7:0] min_val,
  output logic [7:0] max_val
`endif
);

  localparam int N  = 1 << AVG_LOG2;
  localparam int SW = 8 + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic                finish_d;
  logic                edge_det;
  logic                cap_q;
  logic [7:0]          sample_q;
  logic [7:0]          win [N];
  logic [SW-1:0]       sum_q;
  logic [SW-1:0]       sum_new;
  logic [AVG_LOG2-1:0] wr_ptr;
  logic [CW-1:0]       count;
  logic                capture;
  logic                upd_q;
  logic [7:0]          avg_new;

  assign edge_det = finish & ~finish_d;
  // A pending capture is dropped if clr arrives alongside it.
  assign capture  = cap_q & ~clr;
  // Window regs start at zero, so this subtraction is exact even while filling.
  assign sum_new  = sum_q + SW'(sample_q) - SW'(win[wr_ptr]);
  // sum_q holds the post-capture sum during the output cycle.
  assign avg_new  = sum_q[SW-1:AVG_LOG2];

  // Stage 0: edge detect and latch the sample present on the first high cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      finish_d <= 1'b0;
      cap_q    <= 1'b0;
      sample_q <= 8'd0;
    end else begin
      finish_d <= finish;
      cap_q    <= edge_det & ~clr;
      if (edge_det) sample_q <= sample;
    end
  end

  // Stage 1: replace the oldest window entry and update the running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) win[i] <= 8'd0;
      sum_q  <= '0;
      wr_ptr <= '0;
      count  <= '0;
      upd_q  <= 1'b0;
    end else if (clr) begin
      for (int i = 0; i < N; i++) win[i] <= 8'd0;
      sum_q  <= '0;
      wr_ptr <= '0;
      count  <= '0;
      upd_q  <= 1'b0;
    end else begin
      upd_q <= cap_q;
      if (cap_q) begin
        win[wr_ptr] <= sample_q;
        sum_q       <= sum_new;
        wr_ptr      <= wr_ptr + AVG_LOG2'(1);
        if (count != CW'(N)) count <= count + CW'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FILL;
    else      state_q <= state_d;
  end

  // FSM next state: RUN once the window has been filled, back to FILL on clr.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL: if (capture && count == CW'(N - 1)) state_d = RUN;
      RUN:  if (clr) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM outputs.
  always_comb begin
    full      = (state_q == RUN);
    state_dbg = state_q;
  end

  // Stage 2: publish the mean and evaluate the alarm on the new value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      avg       <= 8'd0;
      avg_valid <= 1'b0;
      alarm     <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (upd_q && !clr) begin
        avg <= avg_new;
        if (full) begin
          avg_valid <= 1'b1;
          if (avg_new >= HI_TH)      alarm <= 1'b1;
          else if (avg_new <= LO_TH) alarm <= 1'b0;
        end
      end
    end
  end

`ifdef ADC_MINMAX_EN
  // Extremes of every published full-window mean since reset/clr.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      min_val <= 8'hFF;
      max_val <= 8'h00;
    end else if (clr) begin
      min_val <= 8'hFF;
      max_val <= 8'h00;
    end else if (upd_q && full) begin
      if (avg_new < min_val) min_val <= avg_new;
      if (avg_new > max_val) max_val <= avg_new;
    end
  end
`endif

endmodule

// File: tb/tb_exin_adc_avg.sv
// Directed testbench for exin_adc_avg (AVG_LOG2=3, HI_TH=200, LO_TH=50).
// Build with +define+ADC_MINMAX_EN to also cover min_val/max_val.
module tb_exin_adc_avg;

  logic       clk;
  logic       rst;
  logic       finish;
  logic [7:0] sample;
  logic       clr;
  logic [7:0] avg;
  logic       avg_valid;
  logic       full;
  logic       alarm;
  logic       state_dbg;
`ifdef ADC_MINMAX_EN
  logic [7:0] min_val;
  logic [7:0] max_val;
`endif

  int checks   = 0;
  int failures = 0;
  int vcnt     = 0;
  int vbase;

  exin_adc_avg #(.AVG_LOG2(3), .HI_TH(8'd200), .LO_TH(8'd50)) dut (
    .clk       (clk),
    .rst       (rst),
    .finish    (finish),
    .sample    (sample),
    .clr       (clr),
    .avg       (avg),
    .avg_valid (avg_valid),
    .full      (full),
    .alarm     (alarm),
    .state_dbg (state_dbg)
`ifdef ADC_MINMAX_EN
    ,
    .min_val   (min_val),
    .max_val   (max_val)
`endif
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count avg_valid strobes, sampled away from the active edge.
  always @(negedge clk) if (avg_valid) vcnt++;

  // Scoreboard-style comparison helper
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Driver: one-cycle finish pulse, then let the pipeline settle.
  task automatic pulse(input logic [7:0] v);
    @(negedge clk);
    finish = 1'b1;
    sample = v;
    @(negedge clk);
    finish = 1'b0;
    idle(4);
  endtask

  initial begin
    rst    = 1'b0;
    finish = 1'b0;
    sample = 8'd0;
    clr    = 1'b0;
    idle(3);
    chk("reset_avg", avg, 0);
    chk("reset_valid", avg_valid, 0);
    chk("reset_full", full, 0);
    chk("reset_alarm", alarm, 0);
`ifdef ADC_MINMAX_EN
    chk("reset_min", min_val, 8'hFF);
    chk("reset_max", max_val, 8'h00);
`endif
    rst = 1'b1;
    idle(2);

    // Test 1: fill with 100, exact latency on the 8th capture.
    vbase = vcnt;
    for (int i = 0; i < 7; i++) pulse(8'd100);
    chk("t1_fill_full", full, 0);
    chk("t1_fill_valid_cnt", vcnt - vbase, 0);
    chk("t1_fill_avg", avg, 87);            // 700 >> 3
    @(negedge clk);
    finish = 1'b1;
    sample = 8'd100;
    @(negedge clk);                         // after capture edge
    finish = 1'b0;
    chk("t1_lat_e0_valid", avg_valid, 0);
    @(negedge clk);                         // after sum/count edge
    chk("t1_lat_e1_valid", avg_valid, 0);
    chk("t1_lat_e1_full", full, 1);
    @(negedge clk);                         // after avg edge
    chk("t1_lat_e2_valid", avg_valid, 1);
    chk("t1_avg", avg, 100);
    chk("t1_alarm", alarm, 0);
    idle(3);
    chk("t1_valid_cnt", vcnt - vbase, 1);
`ifdef ADC_MINMAX_EN
    chk("t1_min", min_val, 100);
    chk("t1_max", max_val, 100);
`endif

    // Test 2: step toward 220, alarm sets at 205.
    for (int i = 0; i < 6; i++) pulse(8'd220);
    chk("t2_avg_190", avg, 190);
    chk("t2_alarm_190", alarm, 0);
    pulse(8'd220);
    chk("t2_avg_205", avg, 205);
    chk("t2_alarm_205", alarm, 1);
    pulse(8'd220);
    chk("t2_avg_220", avg, 220);
`ifdef ADC_MINMAX_EN
    chk("t2_min", min_val, 100);
    chk("t2_max", max_val, 220);
`endif

    // Test 3: descend with 40, alarm holds until avg <= 50.
    pulse(8'd40);
    chk("t3_avg_197", avg, 197);
    chk("t3_alarm_197", alarm, 1);
    for (int i = 0; i < 6; i++) pulse(8'd40);
    chk("t3_avg_62", avg, 62);
    chk("t3_alarm_62", alarm, 1);
    pulse(8'd40);
    chk("t3_avg_40", avg, 40);
    chk("t3_alarm_40", alarm, 0);

    // Test 4: finish held high 20 cycles, sample changing: one capture of 120.
    vbase = vcnt;
    @(negedge clk);
    finish = 1'b1;
    sample = 8'd120;
    for (int i = 1; i < 20; i++) begin
      @(negedge clk);
      sample = 8'(130 + i * 7);
    end
    @(negedge clk);
    finish = 1'b0;
    idle(4);
    chk("t4_valid_cnt", vcnt - vbase, 1);
    chk("t4_avg", avg, 50);                 // (7*40 + 120) >> 3

    // Test 5: clr coincident with an edge drops the sample.
    vbase = vcnt;
    @(negedge clk);
    clr    = 1'b1;
    finish = 1'b1;
    sample = 8'd255;
    @(negedge clk);
    clr    = 1'b0;
    finish = 1'b0;
    idle(4);
    chk("t5_full", full, 0);
    chk("t5_state", state_dbg, 0);
    chk("t5_valid_cnt", vcnt - vbase, 0);
    chk("t5_avg_kept", avg, 50);
`ifdef ADC_MINMAX_EN
    chk("t5_min", min_val, 8'hFF);
    chk("t5_max", max_val, 8'h00);
`endif
    for (int i = 0; i < 7; i++) pulse(8'd10);
    chk("t5_fill_avg", avg, 8);             // 70 >> 3 proves the 255 was dropped
    chk("t5_fill_full", full, 0);
    chk("t5_fill_valid_cnt", vcnt - vbase, 0);
    pulse(8'd10);
    chk("t5_avg", avg, 10);
    chk("t5_full_after", full, 1);
    chk("t5_valid_cnt_after", vcnt - vbase, 1);

    // Test 6: async reset mid-window.
    for (int i = 0; i < 8; i++) pulse(8'd250);
    chk("t6_avg_250", avg, 250);
    chk("t6_alarm_250", alarm, 1);
    for (int i = 0; i < 5; i++) pulse(8'd240);
    chk("t6_avg_243", avg, 243);            // (3*250 + 5*240) >> 3
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_avg", avg, 0);
    chk("t6_rst_valid", avg_valid, 0);
    chk("t6_rst_full", full, 0);
    chk("t6_rst_alarm", alarm, 0);
`ifdef ADC_MINMAX_EN
    chk("t6_rst_min", min_val, 8'hFF);
    chk("t6_rst_max", max_val, 8'h00);
`endif
    @(negedge clk);
    rst = 1'b1;
    vbase = vcnt;
    for (int i = 0; i < 7; i++) pulse(8'd80);
    chk("t6_refill_avg", avg, 70);          // 560 >> 3
    chk("t6_refill_full", full, 0);
    chk("t6_refill_valid_cnt", vcnt - vbase, 0);
    pulse(8'd80);
    chk("t6_avg", avg, 80);
    chk("t6_full", full, 1);
    chk("t6_valid_cnt", vcnt - vbase, 1);
`ifdef ADC_MINMAX_EN
    chk("t6_min", min_val, 80);
    chk("t6_max", max_val, 80);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
